// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the parity helper.
// Used by uart_tx_frame and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Data is zero-extended to 9 bits; the extra zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit cycle counter. Counts 0..CYCLES_PER_BIT-1 while enabled and strobes
// bit_end on the last cycle of each bit time. clr restarts the bit time.
module uart_baud_gen #(
    parameter int CYCLES_PER_BIT = 434
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Bit-time counter, wraps on each bit boundary.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: START, DATA_BITS data (LSB first), optional
// parity, STOP_BITS stop bits; every bit lasts CLK_FREQ/BAUD_RATE clocks.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state; when
// undefined the PARITY parameter is ignored and no parity bit is sent).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_par
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           idx_q, idx_d;
    logic                 tx_d, done_d;
    logic                 handshake, bit_end;

    assign tx_ready  = (state_q == ST_IDLE);
    assign tx_busy   = ~tx_ready;
    assign handshake = tx_valid && tx_ready;

    uart_baud_gen #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_baud (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .en      (state_q != ST_IDLE),
        .clr     (handshake),
        .bit_end (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY != PARITY_NONE);
    logic par_q;

    // Parity of the captured word, latched with it.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            par_q <= 1'b0;
        else if (handshake)
            par_q <= parity_bit(9'(tx_data), PARITY);
    end
`endif

    // State register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: every state advances on a bit boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tx_valid) state_d = ST_START;
            ST_START: if (bit_end)  state_d = ST_DATA;
            ST_DATA:  if (bit_end && idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                state_d = PAR_ON ? ST_PARITY : ST_STOP;
`else
                state_d = ST_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP:  if (bit_end && idx_q == LAST_STOP) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: next datapath values and the line level of the next state,
    // so tx changes on the same edge as the state.
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (handshake) begin
            shreg_d = tx_data;
            idx_d   = '0;
        end else if (bit_end && (state_q == ST_DATA || state_q == ST_STOP)) begin
            idx_d = (state_d != state_q) ? 4'd0 : idx_q + 4'd1;
            if (state_q == ST_DATA)
                shreg_d = shreg_q >> 1;
        end
        if (state_q == ST_STOP && state_d == ST_IDLE)
            done_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx      <= tx_d;
            tx_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame at CYCLES_PER_BIT = 10: 8N1 and 5N2 instances, plus
// even/odd parity instances when UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int CPB = 10;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = '0;
    logic       vld[4];
    logic       rdy[4], txl[4], bsy[4], dn[4];

    always #5 clk_50M = ~clk_50M;

    uart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u8n1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .tx_data(din), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5), .STOP_BITS(2), .PARITY(0)) u5n2 (
        .clk_50M(clk_50M), .rst_n(rst_n), .tx_data(din[4:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

`ifdef UART_TX_PARITY_EN
    uart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u8e1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .tx_data(din), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u8o1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .tx_data(din), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));
`else
    assign rdy[2] = 1'b1; assign txl[2] = 1'b1; assign bsy[2] = 1'b0; assign dn[2] = 1'b0;
    assign rdy[3] = 1'b1; assign txl[3] = 1'b1; assign bsy[3] = 1'b0; assign dn[3] = 1'b0;
`endif

    typedef struct {
        logic [12:0] bits;   // bit i = line level of slot i
        int          slots;
        int          hs;     // cycle count at the handshake edge
    } exp_t;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [12:0] bits;
        int          slots;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];

    int nerr = 0, nchk = 0;
    int cyc = 0, sel = 0;
    int frames_done = 0, last_done_cyc = -100, last_gap = 0;
    int t = 0;
    bit active = 0, chk_low = 0, prev_tx = 1;
    exp_t cur;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference frame builder: start, data LSB first, optional parity, stops.
    function automatic exp_t mk_frame(input logic [7:0] d, input int nb, input int par, input int ns);
        exp_t e;
        int   k;
        logic p;
        e.bits = '0;
        e.hs   = 0;
        k      = 1;
        p      = 1'b0;
        for (int i = 0; i < nb; i++) begin
            e.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (par != PARITY_NONE) begin
            e.bits[k] = (par == PARITY_ODD) ? ~p : p;
            k++;
        end
        for (int i = 0; i < ns; i++) begin
            e.bits[k] = 1'b1;
            k++;
        end
        e.slots = k;
        return e;
    endfunction

    // Monitor: frame starts on a falling line edge, levels sampled mid-slot,
    // tx_done checked at the exact frame end and for a single-cycle width.
    always @(negedge clk_50M) begin
        if (chk_low) begin
            chk(dn[sel] == 1'b0, "done_one_cycle", dn[sel], 0);
            chk_low = 0;
        end
        if (!rst_n) begin
            active = 0;
        end else if (active) begin
            t = t + 1;
            if (t % CPB == CPB / 2 && t / CPB < cur.slots)
                chk(txl[sel] == cur.bits[t / CPB], "slot_level", txl[sel], cur.bits[t / CPB]);
            if (t == cur.slots * CPB - 1)
                chk(dn[sel] == 1'b0, "done_early", dn[sel], 0);
            if (t == cur.slots * CPB) begin
                chk(dn[sel] == 1'b1, "done_at_frame_end", dn[sel], 1);
                last_done_cyc = cyc;
                active  = 0;
                chk_low = 1;
                frames_done++;
            end
        end else if (prev_tx && !txl[sel] && sbq.size() > 0) begin
            cur      = sbq.pop_front();
            active   = 1;
            t        = 0;
            last_gap = cyc - last_done_cyc;
            chk(cyc == cur.hs, "start_latency", cyc, cur.hs);
        end
        prev_tx = txl[sel];
    end

    // Present a word to instance s and wait for the handshake; optionally
    // keep tx_valid high afterwards.
    task automatic send(input int s, input logic [7:0] d, input exp_t e, input bit push, input bit hold);
        int n;
        @(negedge clk_50M);
        sel    = s;
        din    = d;
        vld[s] = 1'b1;
        n      = 0;
        while (!rdy[s] && n < 300) begin
            @(negedge clk_50M);
            n++;
        end
        if (!rdy[s]) begin
            chk(1'b0, "ready_timeout", 0, 1);
            vld[s] = 1'b0;
            return;
        end
        if (push) begin
            e.hs = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk_50M);
        #1;
        if (!hold) vld[s] = 1'b0;
        @(negedge clk_50M);
        chk(bsy[s] == 1'b1 && rdy[s] == 1'b0, "busy_after_handshake", bsy[s], 1);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 400) begin
            @(negedge clk_50M);
            n++;
        end
        chk(frames_done >= target, "frame_timeout", frames_done, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   target;
        int   gap;
        bit   seen_done, seen_low;

        for (int i = 0; i < 4; i++) vld[i] = 1'b0;

        vecs.push_back('{0, 8'hA5, 13'h34A, 10});
        vecs.push_back('{0, 8'h00, 13'h200, 10});
        vecs.push_back('{0, 8'hFF, 13'h3FE, 10});
        vecs.push_back('{0, 8'h01, 13'h202, 10});
        vecs.push_back('{0, 8'h80, 13'h300, 10});
        vecs.push_back('{1, 8'h1F, 13'h0FE, 8});
        vecs.push_back('{1, 8'h0A, 13'h0D4, 8});
`ifdef UART_TX_PARITY_EN
        vecs.push_back('{2, 8'h07, 13'h60E, 11});
        vecs.push_back('{3, 8'h07, 13'h40E, 11});
`endif

        // Reset state
        #12;
        for (int i = 0; i < 2; i++) begin
            chk(txl[i] == 1'b1, "reset_tx", txl[i], 1);
            chk(rdy[i] == 1'b1, "reset_ready", rdy[i], 1);
            chk(bsy[i] == 1'b0, "reset_busy", bsy[i], 0);
            chk(dn[i] == 1'b0, "reset_done", dn[i], 0);
        end
        @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);

        // Table-driven frames
        target = frames_done;
        for (int i = 0; i < vecs.size(); i++) begin
            e.bits  = vecs[i].bits;
            e.slots = vecs[i].slots;
            e.hs    = 0;
            send(vecs[i].sel, vecs[i].data, e, 1'b1, 1'b0);
            target++;
            wait_frames(target);
            repeat (3) @(negedge clk_50M);
        end

        // Back-to-back with tx_valid held; data changed mid-frame
        send(0, 8'h55, mk_frame(8'h55, 8, PARITY_NONE, 1), 1'b1, 1'b1);
        din = 8'hAA;
        send(0, 8'hAA, mk_frame(8'hAA, 8, PARITY_NONE, 1), 1'b1, 1'b0);
        target += 2;
        wait_frames(target);
        gap = last_gap;
        chk(gap == 1, "b2b_gap_after_done", gap, 1);
        repeat (3) @(negedge clk_50M);

        // Reset during data bit 3 of 0xF0
        send(0, 8'hF0, mk_frame(8'hF0, 8, PARITY_NONE, 1), 1'b0, 1'b0);
        repeat (44) @(negedge clk_50M);
        chk(txl[0] == 1'b0, "abort_pre_tx", txl[0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk(txl[0] == 1'b1, "abort_tx_async", txl[0], 1);
        chk(rdy[0] == 1'b1, "abort_ready", rdy[0], 1);
        chk(bsy[0] == 1'b0, "abort_busy", bsy[0], 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        seen_done = 0;
        seen_low  = 0;
        repeat (100) begin
            @(negedge clk_50M);
            if (dn[0]) seen_done = 1;
            if (!txl[0]) seen_low = 1;
        end
        chk(!seen_done, "abort_no_done", seen_done, 0);
        chk(!seen_low, "abort_line_idle", seen_low, 0);

        // Fresh frame after reset
        e.bits  = 13'h278;
        e.slots = 10;
        e.hs    = 0;
        send(0, 8'h3C, e, 1'b1, 1'b0);
        target++;
        wait_frames(target);
        repeat (3) @(negedge clk_50M);
        chk(sbq.size() == 0, "scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
